// File: rtl/rob_redirect_ctrl_pkg.sv
// Shared types for the ROB redirect controller: address type and the recovery FSM state encoding.
package rob_redirect_ctrl_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2,
        RECOVER  = 2'd3
    } rob_redirect_state_t;

endpackage

// File: rtl/rob_redirect_ctrl_if.sv
// Signal bundle between the ROB retire side, the fetch/dispatch front end and the redirect controller.
interface rob_redirect_ctrl_if
    import rob_redirect_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16
);

    logic                 retire;
    logic                 retire_redirect_pc_valid;
    addr_t                retire_redirect_pc;
    logic                 flush;
    // fetch_redirect_valid/ready: a transfer happens on a clock edge where both are high;
    // once valid rises, it and fetch_redirect_pc hold steady until that edge.
    logic                 fetch_redirect_valid;
    logic                 fetch_redirect_ready;
    addr_t                fetch_redirect_pc;
    logic                 dispatch_stall;
    logic                 busy;
    logic [CNT_WIDTH-1:0] redirect_count;
    rob_redirect_state_t  state;

    modport master (
        input  retire,
        input  retire_redirect_pc_valid,
        input  retire_redirect_pc,
        input  fetch_redirect_ready,
        output flush,
        output fetch_redirect_valid,
        output fetch_redirect_pc,
        output dispatch_stall,
        output busy,
        output redirect_count,
        output state
    );

    modport slave (
        output retire,
        output retire_redirect_pc_valid,
        output retire_redirect_pc,
        output fetch_redirect_ready,
        input  flush,
        input  fetch_redirect_valid,
        input  fetch_redirect_pc,
        input  dispatch_stall,
        input  busy,
        input  redirect_count,
        input  state
    );

endinterface

// File: rtl/rob_redirect_ctrl_sat_counter.sv
// Up-counter that sticks at its all-ones maximum instead of wrapping.
module rob_redirect_ctrl_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rob_redirect_ctrl.sv
// Misprediction recovery sequencer: flush pulse, corrected PC to fetch, then a dispatch settle window.
module rob_redirect_ctrl
    import rob_redirect_ctrl_pkg::*;
#(
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_WIDTH      = 16
) (
    input logic                 clk,
    input logic                 rst_aL,
    rob_redirect_ctrl_if.master bus
);

    localparam int            RW       = $clog2(RECOVER_CYCLES + 1);
    localparam logic [RW-1:0] REC_INIT = RW'(RECOVER_CYCLES - 1);

    rob_redirect_state_t state;
    addr_t               pc_q;
    logic [RW-1:0]       rec_cnt;
    logic                accept;
    logic                unused_retire;

    // Retirement itself does not gate the redirect; the mispredict flag alone decides.
    assign unused_retire = bus.retire;

    // Requests outside IDLE refer to already-flushed instructions and are dropped.
    assign accept = (state == IDLE) && bus.retire_redirect_pc_valid;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state   <= IDLE;
            pc_q    <= '0;
            rec_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pc_q  <= bus.retire_redirect_pc;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= REDIRECT;
                end
                REDIRECT: begin
                    if (bus.fetch_redirect_ready) begin
                        rec_cnt <= REC_INIT;
                        state   <= RECOVER;
                    end
                end
                RECOVER: begin
                    if (rec_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        rec_cnt <= rec_cnt - RW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.flush                = (state == FLUSH);
    assign bus.fetch_redirect_valid = (state == REDIRECT);
    assign bus.fetch_redirect_pc    = pc_q;
    assign bus.busy                 = (state != IDLE);
    assign bus.state                = state;
    // The mispredicting cycle itself must not dispatch, hence the combinational term in IDLE.
    assign bus.dispatch_stall       = (state != IDLE) || bus.retire_redirect_pc_valid;

    rob_redirect_ctrl_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_redirect_count (
        .clk    (clk),
        .rst_aL (rst_aL),
        .inc    (accept),
        .count  (bus.redirect_count)
    );

endmodule

// File: tb/tb_rob_redirect_ctrl.sv
// Directed bench for rob_redirect_ctrl: expected flush cycles and handshakes are queued and checked by a monitor.
module tb_rob_redirect_ctrl;
    import rob_redirect_ctrl_pkg::*;

    logic clk;
    logic rst_aL;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic [31:0] flush_q[$];
    logic [47:0] hs_q[$];

    rob_redirect_ctrl_if #(.CNT_WIDTH(16)) bus1 ();
    rob_redirect_ctrl_if #(.CNT_WIDTH(2))  bus2 ();

    rob_redirect_ctrl #(.RECOVER_CYCLES(2), .CNT_WIDTH(16)) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (bus1.master)
    );

    rob_redirect_ctrl #(.RECOVER_CYCLES(2), .CNT_WIDTH(2)) dut_sat (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (bus2.master)
    );

    // clock / reset / cycle count
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [31:0] ef;
        logic [47:0] eh;
        if (bus1.flush) begin
            n_checks++;
            if (flush_q.size() == 0) begin
                n_fail++;
                $display("FAIL flush_unexpected: flush=1 at cycle %0d, none expected", cyc);
            end else begin
                ef = flush_q.pop_front();
                if (32'(cyc) != ef) begin
                    n_fail++;
                    $display("FAIL flush_cycle: got cycle %0d, expected cycle %0d", cyc, ef);
                end
            end
        end
        if (bus1.fetch_redirect_valid) begin
            n_checks++;
            if (hs_q.size() == 0) begin
                n_fail++;
                $display("FAIL valid_unexpected: fetch_redirect_valid=1 at cycle %0d", cyc);
            end else begin
                if (bus1.fetch_redirect_pc !== hs_q[0][31:0]) begin
                    n_fail++;
                    $display("FAIL redirect_pc: got 0x%0h, expected 0x%0h", bus1.fetch_redirect_pc, hs_q[0][31:0]);
                end
                if (bus1.fetch_redirect_ready) begin
                    eh = hs_q.pop_front();
                    n_checks++;
                    if (bus1.redirect_count !== eh[47:32]) begin
                        n_fail++;
                        $display("FAIL hs_count: got %0d, expected %0d", bus1.redirect_count, eh[47:32]);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            bus1.retire_redirect_pc_valid = 1'b0;
            bus1.fetch_redirect_ready     = 1'b1;
            @(negedge clk);
            check("idle_stall", 64'(bus1.dispatch_stall), 64'd0);
            check("idle_busy", 64'(bus1.busy), 64'd0);
        end
    endtask

    // One redirect: d cycles of fetch backpressure, optional stale requests while busy.
    task automatic run_seq(input addr_t pc, input int d, input bit noise, input int exp_cnt);
        step();
        bus1.retire_redirect_pc_valid = 1'b1;
        bus1.retire_redirect_pc       = pc;
        bus1.retire                   = 1'b1;
        flush_q.push_back(32'(cyc + 1));
        hs_q.push_back({16'(exp_cnt), pc});
        @(negedge clk);
        check("req_stall", 64'(bus1.dispatch_stall), 64'd1);
        check("req_busy", 64'(bus1.busy), 64'd0);
        for (int k = 1; k <= 4 + d; k++) begin
            step();
            bus1.retire                   = 1'b0;
            bus1.retire_redirect_pc_valid = noise;
            if (noise) bus1.retire_redirect_pc = 32'h0000_2000;
            bus1.fetch_redirect_ready = !(k >= 2 && k < 2 + d);
            @(negedge clk);
            check("seq_stall", 64'(bus1.dispatch_stall), 64'd1);
            check("seq_busy", 64'(bus1.busy), 64'd1);
            check("seq_valid", 64'(bus1.fetch_redirect_valid), 64'(k >= 2 && k <= 2 + d));
        end
        check("seq_pc_held", 64'(bus1.fetch_redirect_pc), 64'(pc));
        check("seq_count", 64'(bus1.redirect_count), 64'(exp_cnt));
    endtask

    initial begin
        int exp_sat[5];
        exp_sat = '{1, 2, 3, 3, 3};
        n_checks = 0;
        n_fail   = 0;
        rst_aL   = 1'b0;
        bus1.retire = 1'b0;
        bus1.retire_redirect_pc_valid = 1'b0;
        bus1.retire_redirect_pc = '0;
        bus1.fetch_redirect_ready = 1'b1;
        bus2.retire = 1'b0;
        bus2.retire_redirect_pc_valid = 1'b0;
        bus2.retire_redirect_pc = 32'h0000_0800;
        bus2.fetch_redirect_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flush", 64'(bus1.flush), 64'd0);
        check("rst_valid", 64'(bus1.fetch_redirect_valid), 64'd0);
        check("rst_pc", 64'(bus1.fetch_redirect_pc), 64'd0);
        check("rst_stall", 64'(bus1.dispatch_stall), 64'd0);
        check("rst_busy", 64'(bus1.busy), 64'd0);
        check("rst_count", 64'(bus1.redirect_count), 64'd0);
        check("rst_state", 64'(bus1.state), 64'(IDLE));
        step();
        rst_aL = 1'b1;
        idle_cycles(2);

        run_seq(32'h0000_1040, 0, 1'b0, 1);
        idle_cycles(2);
        run_seq(32'h0000_1100, 5, 1'b0, 2);
        idle_cycles(2);
        run_seq(32'h0000_1200, 0, 1'b1, 3);
        idle_cycles(2);
        run_seq(32'h0000_1300, 0, 1'b0, 4);
        run_seq(32'h0000_1340, 0, 1'b0, 5);
        idle_cycles(2);

        // reset while REDIRECT waits on fetch
        step();
        bus1.retire_redirect_pc_valid = 1'b1;
        bus1.retire_redirect_pc       = 32'h0000_3000;
        bus1.fetch_redirect_ready     = 1'b0;
        flush_q.push_back(32'(cyc + 1));
        hs_q.push_back({16'd6, 32'h0000_3000});
        step();
        bus1.retire_redirect_pc_valid = 1'b0;
        step();
        @(negedge clk);
        check("pre_rst_valid", 64'(bus1.fetch_redirect_valid), 64'd1);
        #2;
        rst_aL = 1'b0;
        hs_q.delete();
        #1;
        check("arst_flush", 64'(bus1.flush), 64'd0);
        check("arst_valid", 64'(bus1.fetch_redirect_valid), 64'd0);
        check("arst_pc", 64'(bus1.fetch_redirect_pc), 64'd0);
        check("arst_stall", 64'(bus1.dispatch_stall), 64'd0);
        check("arst_busy", 64'(bus1.busy), 64'd0);
        check("arst_count", 64'(bus1.redirect_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_aL = 1'b1;
        bus1.fetch_redirect_ready = 1'b1;
        idle_cycles(3);
        check("post_rst_count", 64'(bus1.redirect_count), 64'd0);
        check("post_rst_state", 64'(bus1.state), 64'(IDLE));
        run_seq(32'h0000_4000, 0, 1'b0, 1);
        idle_cycles(2);

        // saturating counter on the narrow instance
        for (int i = 0; i < 5; i++) begin
            step();
            bus2.retire_redirect_pc_valid = 1'b1;
            step();
            bus2.retire_redirect_pc_valid = 1'b0;
            repeat (5) step();
            @(negedge clk);
            check("sat_count", 64'(bus2.redirect_count), 64'(exp_sat[i]));
            check("sat_busy", 64'(bus2.busy), 64'd0);
        end

        check("flush_q_drained", 64'(flush_q.size()), 64'd0);
        check("hs_q_drained", 64'(hs_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
